time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Controller that sequences three cascaded modulo counters (seconds, minutes, hours) forming a 24-hour time-of-day clock. In RUN mode it turns the 1 Hz tick into incr pulses with carry propagation. In SET modes it freezes timekeeping and maps operator buttons onto per-field incr/set_data strobes. It sits between the button/tick front end and the three counter instances; the counters keep ownership of the stored values and their wrap-around.

Parameters:
SEC_MOD, 60, seconds counter modulus
MIN_MOD, 60, minutes counter modulus
HOUR_MOD, 24, hours counter modulus
SEC_BITS, $clog2(SEC_MOD), seconds value width
MIN_BITS, $clog2(MIN_MOD), minutes value width
REPEAT_DELAY, 16, clk cycles btn_inc must stay high before auto-repeat starts
REPEAT_PERIOD, 4, clk cycles between auto-repeat pulses

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0)
tick  in  1  one-cycle 1 Hz enable pulse
btn_mode  in  1  synchronized, debounced mode button level
btn_inc  in  1  synchronized, debounced increment button level
sec_val  in  SEC_BITS  current seconds counter value
min_val  in  MIN_BITS  current minutes counter value
sec_incr  out  1  seconds counter incr
min_incr  out  1  minutes counter incr
hour_incr  out  1  hours counter incr
sec_set  out  1  seconds counter set_data
sec_data  out  SEC_BITS  seconds load value; constant 0
edit_field  out  2  0=none (RUN), 1=hour, 2=min, 3=sec
blink  out  1  display blink phase for the selected field

Behaviour:
- Reset (rst==0 at posedge clk): state RUN. All strobes 0, sec_data 0, edit_field 0, blink 0. Edge-detect history registers 0. Repeat counter 0.
- All outputs are registered. One-cycle latency from the inputs to the strobes.
- Edge detect: mode_rise = btn_mode & ~btn_mode_d, where btn_mode_d is btn_mode registered. inc_rise is formed the same way from btn_inc.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC. Each mode_rise advances the state: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- RUN:
  - sec_incr = tick.
  - min_incr = tick & (sec_val == SEC_MOD-1).
  - hour_incr = tick & (sec_val == SEC_MOD-1) & (min_val == MIN_MOD-1).
  - The hour wrap is left to the hours counter.
- SET_* states: tick never produces incr. Fields are independent, so there is no carry into other fields.
  - SET_HOUR: inc_rise or a repeat pulse gives a single hour_incr.
  - SET_MIN: the same gives a single min_incr.
  - SET_SEC: inc_rise gives sec_set=1 for one cycle, loading 0. There is no auto-repeat in SET_SEC.
- Auto-repeat (SET_HOUR/SET_MIN only):
  - Count clk cycles while btn_inc is high.
  - On reaching REPEAT_DELAY, emit a pulse and reload the count so pulses follow every REPEAT_PERIOD cycles.
  - The counter clears when btn_inc is low or the state changes.
- Simultaneous mode_rise and inc_rise: the mode change wins, the increment is dropped and the repeat counter clears.
- Simultaneous tick and mode_rise in RUN: the tick is still applied (strobes issued) and the state moves to SET_HOUR.
- Leaving SET_SEC for RUN: timekeeping resumes on the next tick; no strobe is issued on the transition.
- blink:
  - 0 in RUN.
  - Toggles on each tick while in a SET state.
  - Forced to 1 on entry to any SET state so the field is visible immediately.
- edit_field follows the state with the same 1-cycle registered latency.
- At most one of the strobe outputs is high in a SET state. In RUN, several may be high together (carry chain).
- Reset mid-operation (any state, button held) returns to RUN. A button already high at release of reset produces no edge until it goes low and high again.

Decomposition:
- Package time_pkg:
  - state enum {RUN, SET_HOUR, SET_MIN, SET_SEC}, 2-bit.
  - edit_field encodings.
  - Default moduli constants.
- Sub-module edge_rise: one-flop rising-edge detector, instantiated twice (mode, inc).
- The repeat timer stays inline.

Test Plan:
- Reset then 3 ticks in RUN, sec_val 0..2 -> sec_incr pulses 3x, min_incr/hour_incr stay 0, edit_field=0, blink=0.
- RUN, sec_val=59, min_val=59, tick -> next cycle sec_incr=min_incr=hour_incr=1. With sec_val=59, min_val=10 -> hour_incr=0.
- Four btn_mode presses -> edit_field 1,2,3,0 in sequence. Ticks in SET_MIN produce no incr. blink toggles per tick in SET states and reads 1 on entry.
- SET_MIN, btn_inc held 30 cycles (REPEAT_DELAY=16, PERIOD=4) -> min_incr at press+1, then at cycles 16, 20, 24, 28 after press: 5 pulses total.
- SET_SEC, btn_inc pulse -> sec_set=1 for one cycle with sec_data=0, no sec_incr. Simultaneous btn_mode+btn_inc rise -> state advances, no strobe.
- rst=0 for one cycle while in SET_HOUR with btn_inc held -> next cycle state RUN, outputs 0. Holding btn_inc after reset gives no hour_incr.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and defaults for the time-of-day set/run controller.
package time_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int DEF_SEC_MOD       = 60;
  localparam int DEF_MIN_MOD       = 60;
  localparam int DEF_HOUR_MOD      = 24;
  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      SET_HOUR: return FIELD_HOUR;
      SET_MIN:  return FIELD_MIN;
      SET_SEC:  return FIELD_SEC;
      default:  return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-flop rising-edge detector. It stays disarmed after reset until the input
// has been seen low, so a button held through reset release is not an edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= armed | ~d;
    end
  end

  assign rise = d & ~d_q & armed;

endmodule

// File: rtl/time_set_ctrl.sv
// Run/set sequencer for cascaded sec/min/hour counters: tick carry in RUN,
// button-driven per-field strobes with auto-repeat in the SET states.
//
// state    | meaning
// RUN      | timekeeping, tick drives incr with carry chain
// SET_HOUR | btn_inc (and auto-repeat) bumps hours
// SET_MIN  | btn_inc (and auto-repeat) bumps minutes
// SET_SEC  | btn_inc clears seconds to 0
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int SEC_MOD       = DEF_SEC_MOD,
  parameter int MIN_MOD       = DEF_MIN_MOD,
  parameter int HOUR_MOD      = DEF_HOUR_MOD,
  parameter int SEC_BITS      = $clog2(SEC_MOD),
  parameter int MIN_BITS      = $clog2(MIN_MOD),
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                btn_mode,
  input  logic                btn_inc,
  input  logic [SEC_BITS-1:0] sec_val,
  input  logic [MIN_BITS-1:0] min_val,
  output logic                sec_incr,
  output logic                min_incr,
  output logic                hour_incr,
  output logic                sec_set,
  output logic [SEC_BITS-1:0] sec_data,
  output logic [1:0]          edit_field,
  output logic                blink
);

  localparam int CNT_BITS = $clog2(REPEAT_DELAY + 1);
  localparam logic [CNT_BITS-1:0] CNT_DELAY  = CNT_BITS'(REPEAT_DELAY);
  // After a repeat pulse the count restarts so the next pulse lands PERIOD cycles later.
  localparam logic [CNT_BITS-1:0] CNT_RELOAD = CNT_BITS'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  if (SEC_MOD < 2 || MIN_MOD < 2 || HOUR_MOD < 2 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_param
    $error("time_set_ctrl: invalid modulus or repeat parameters");
  end

  state_t              state;
  state_t              next_state;
  logic [CNT_BITS-1:0] rep_cnt;
  logic                mode_rise;
  logic                inc_rise;
  logic                sec_wrap;
  logic                min_wrap;
  logic                rep_active;
  logic                rep_pulse;
  logic                bump;

  edge_rise u_mode_edge (.clk(clk), .rst(rst), .d(btn_mode), .rise(mode_rise));
  edge_rise u_inc_edge  (.clk(clk), .rst(rst), .d(btn_inc),  .rise(inc_rise));

  always_comb begin
    next_state = state;
    if (mode_rise) begin
      case (state)
        RUN:      next_state = SET_HOUR;
        SET_HOUR: next_state = SET_MIN;
        SET_MIN:  next_state = SET_SEC;
        default:  next_state = RUN;
      endcase
    end
  end

  assign sec_wrap   = (sec_val == SEC_BITS'(SEC_MOD - 1));
  assign min_wrap   = (min_val == MIN_BITS'(MIN_MOD - 1));
  assign rep_active = btn_inc && !mode_rise && (state == SET_HOUR || state == SET_MIN);
  assign rep_pulse  = rep_active && (rep_cnt == CNT_DELAY);
  // A mode change swallows any increment arriving on the same cycle.
  assign bump       = !mode_rise && (inc_rise || rep_pulse);
  assign sec_data   = '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      rep_cnt    <= '0;
      sec_incr   <= 1'b0;
      min_incr   <= 1'b0;
      hour_incr  <= 1'b0;
      sec_set    <= 1'b0;
      edit_field <= FIELD_NONE;
      blink      <= 1'b0;
    end else begin
      state      <= next_state;
      edit_field <= field_of(next_state);
      sec_incr   <= 1'b0;
      min_incr   <= 1'b0;
      hour_incr  <= 1'b0;
      sec_set    <= 1'b0;

      if (!rep_active)    rep_cnt <= '0;
      else if (rep_pulse) rep_cnt <= CNT_RELOAD;
      else                rep_cnt <= rep_cnt + 1'b1;

      case (state)
        RUN: begin
          sec_incr  <= tick;
          min_incr  <= tick && sec_wrap;
          hour_incr <= tick && sec_wrap && min_wrap;
        end
        SET_HOUR: hour_incr <= bump;
        SET_MIN:  min_incr  <= bump;
        default:  sec_set   <= inc_rise && !mode_rise;
      endcase

      if (next_state == RUN)       blink <= 1'b0;
      else if (next_state != state) blink <= 1'b1;
      else if (tick)               blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scenario bench for time_set_ctrl: expected outputs are queued per driven cycle
// and popped against the registered outputs one cycle later.
module tb_time_set_ctrl;
  import time_pkg::*;

  typedef struct packed {
    logic       si;
    logic       mi;
    logic       hi;
    logic       ss;
    logic [5:0] sd;
    logic [1:0] ef;
    logic       bl;
  } out_t;

  logic       clk = 1'b0;
  logic       rst, tick, btn_mode, btn_inc;
  logic [5:0] sec_val, min_val;
  logic       sec_incr, min_incr, hour_incr, sec_set, blink;
  logic [5:0] sec_data;
  logic [1:0] edit_field;
  out_t       obs;
  out_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_val(sec_val), .min_val(min_val),
    .sec_incr(sec_incr), .min_incr(min_incr), .hour_incr(hour_incr),
    .sec_set(sec_set), .sec_data(sec_data), .edit_field(edit_field), .blink(blink)
  );

  assign obs = {sec_incr, min_incr, hour_incr, sec_set, sec_data, edit_field, blink};

  function automatic out_t mk(input logic si, mi, hi, ss, input logic [1:0] ef, input logic bl);
    out_t o;
    o.si = si; o.mi = mi; o.hi = hi; o.ss = ss; o.sd = 6'd0; o.ef = ef; o.bl = bl;
    return o;
  endfunction

  task automatic test_reset();
    out_t want;
    rst = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    sec_val = 6'd0; min_val = 6'd0;
    sb.push_back(mk(0, 0, 0, 0, FIELD_NONE, 0));
    repeat (2) @(negedge clk);
    want = sb.pop_front();
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset got %h want %h", obs, want);
    end
    rst = 1'b1;
  endtask

  task automatic test_run_ticks();
    out_t want;
    for (int i = 0; i < 6; i++) begin
      tick    = (i % 2 == 0);
      sec_val = 6'(i / 2);
      sb.push_back(mk(tick, 0, 0, 0, FIELD_NONE, 0));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL run_ticks[%0d] got %h want %h", i, obs, want);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_carry();
    logic [5:0] sv[4] = '{6'd59, 6'd0, 6'd59, 6'd58};
    logic [5:0] mv[4] = '{6'd59, 6'd59, 6'd10, 6'd59};
    logic [0:3] t_s  = 4'b1011;
    logic [0:3] si_s = 4'b1011;
    logic [0:3] mi_s = 4'b1010;
    logic [0:3] hi_s = 4'b1000;
    out_t want;
    for (int i = 0; i < 4; i++) begin
      tick = t_s[i]; sec_val = sv[i]; min_val = mv[i];
      sb.push_back(mk(si_s[i], mi_s[i], hi_s[i], 0, FIELD_NONE, 0));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL carry[%0d] got %h want %h", i, obs, want);
      end
    end
    tick = 1'b0; sec_val = 6'd0; min_val = 6'd0;
  endtask

  task automatic test_modes();
    logic [0:8] m_s  = 9'b101001010;
    logic [0:8] t_s  = 9'b010110111;
    logic [0:8] si_s = 9'b000000001;
    logic [0:8] bl_s = 9'b101011000;
    logic [1:0] ef_s[9] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    out_t want;
    for (int i = 0; i < 9; i++) begin
      btn_mode = m_s[i]; tick = t_s[i];
      sb.push_back(mk(si_s[i], 0, 0, 0, ef_s[i], bl_s[i]));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL modes[%0d] got %h want %h", i, obs, want);
      end
    end
    btn_mode = 1'b0; tick = 1'b0;
  endtask

  task automatic test_repeat();
    logic [0:3] m_s = 4'b1010;
    logic [1:0] ef_s[4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic       pulse;
    int         pulses = 0;
    out_t       want;
    for (int i = 0; i < 4; i++) begin
      btn_mode = m_s[i];
      sb.push_back(mk(0, 0, 0, 0, ef_s[i], 1));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL repeat_enter[%0d] got %h want %h", i, obs, want);
      end
    end
    for (int j = 0; j < 34; j++) begin
      btn_inc = (j < 30);
      pulse = (j == 0 || j == 16 || j == 20 || j == 24 || j == 28);
      sb.push_back(mk(0, pulse, 0, 0, FIELD_MIN, 1));
      @(negedge clk);
      if (min_incr === 1'b1) pulses++;
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL repeat_hold[%0d] got %h want %h", j, obs, want);
      end
    end
    n_chk++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL repeat_count got %0d want 5", pulses);
    end
  endtask

  task automatic test_set_sec();
    logic [0:10] m_s  = 11'b10000101010;
    logic [0:10] i_s  = 11'b00110101010;
    logic [0:10] ss_s = 11'b00100000000;
    logic [0:10] bl_s = 11'b11111001111;
    logic [1:0]  ef_s[11] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    out_t want;
    for (int i = 0; i < 11; i++) begin
      btn_mode = m_s[i]; btn_inc = i_s[i];
      sb.push_back(mk(0, 0, 0, ss_s[i], ef_s[i], bl_s[i]));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL set_sec[%0d] got %h want %h", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:17] r_s  = 18'b111111110111111111;
    logic [0:17] m_s  = 18'b101010001110100000;
    logic [0:17] i_s  = 18'b000000111111111010;
    logic [0:17] hi_s = 18'b000000100000000010;
    logic [0:17] bl_s = 18'b110011110000111111;
    logic [1:0]  ef_s[18] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                              2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    out_t want;
    for (int i = 0; i < 18; i++) begin
      rst = r_s[i]; btn_mode = m_s[i]; btn_inc = i_s[i];
      sb.push_back(mk(0, 0, hi_s[i], 0, ef_s[i], bl_s[i]));
      @(negedge clk);
      want = sb.pop_front();
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got %h want %h", i, obs, want);
      end
    end
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_carry();
    test_modes();
    test_repeat();
    test_set_sec();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
